// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational imem address and
// registers the fetched instruction or fetch fault into an IF/ID valid/ready slot.
module fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0000_0000_0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_en,
    input  logic [63:0] redirect_pc,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        imem_exc_en,
    input  logic [3:0]  imem_exc_code,
    input  logic [63:0] imem_exc_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_exc_en,
    output logic [3:0]  out_exc_code,
    output logic [63:0] out_exc_val,
    output logic        fetch_halted
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [63:0] opc_q, opc_d;
    logic [31:0] instr_q, instr_d;
    logic        exc_en_q, exc_en_d;
    logic [3:0]  exc_code_q, exc_code_d;
    logic [63:0] exc_val_q, exc_val_d;

    logic        load;
    logic        misaligned;
    logic        fetch_exc;
    logic [3:0]  fetch_code;
    logic [63:0] fetch_val;

    // Misalignment is detected locally and outranks whatever imem reports.
    assign misaligned = (pc_q[1:0] != 2'b00);
    assign fetch_exc  = misaligned || imem_exc_en;
    assign fetch_code = misaligned ? 4'd0 : imem_exc_code;
    assign fetch_val  = misaligned ? pc_q : imem_exc_val;

    assign load = (state_q == ST_RUN) && (!valid_q || out_ready) && !redirect_en;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        opc_d      = opc_q;
        instr_d    = instr_q;
        exc_en_d   = exc_en_q;
        exc_code_d = exc_code_q;
        exc_val_d  = exc_val_q;

        if (redirect_en) begin
            // A redirect voids any handshake in the same cycle.
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            state_d = ST_RUN;
        end else if (load) begin
            valid_d = 1'b1;
            opc_d   = pc_q;
            if (fetch_exc) begin
                instr_d    = NOP_INSTR;
                exc_en_d   = 1'b1;
                exc_code_d = fetch_code;
                exc_val_d  = fetch_val;
                state_d    = ST_HALT;
            end else begin
                instr_d    = imem_instr;
                exc_en_d   = 1'b0;
                exc_code_d = 4'd0;
                exc_val_d  = 64'd0;
                pc_d       = pc_q + 64'd4;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            opc_q      <= 64'd0;
            instr_q    <= NOP_INSTR;
            exc_en_q   <= 1'b0;
            exc_code_q <= 4'd0;
            exc_val_q  <= 64'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            opc_q      <= opc_d;
            instr_q    <= instr_d;
            exc_en_q   <= exc_en_d;
            exc_code_q <= exc_code_d;
            exc_val_q  <= exc_val_d;
        end
    end

    assign imem_addr    = pc_q;
    assign out_valid    = valid_q;
    assign out_pc       = opc_q;
    assign out_instr    = instr_q;
    assign out_exc_en   = exc_en_q;
    assign out_exc_code = exc_code_q;
    assign out_exc_val  = exc_val_q;
    assign fetch_halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a synthetic imem, a stream-level reference model feeding a
// scoreboard queue, and a negedge monitor that checks every accepted entry.
module tb_fetch_stage;

    localparam logic [63:0] RESET_PC  = 64'h0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_en;
    logic [63:0] redirect_pc;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        imem_exc_en;
    logic [3:0]  imem_exc_code;
    logic [63:0] imem_exc_val;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_exc_en;
    logic [3:0]  out_exc_code;
    logic [63:0] out_exc_val;
    logic        fetch_halted;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk(clk), .rst(rst),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .imem_exc_en(imem_exc_en), .imem_exc_code(imem_exc_code), .imem_exc_val(imem_exc_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .out_exc_en(out_exc_en), .out_exc_code(out_exc_code), .out_exc_val(out_exc_val),
        .fetch_halted(fetch_halted)
    );

    // ---------------- environment: synthetic instruction memory ----------------
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0003;
    endfunction

    function automatic logic fault_at(input logic [63:0] a);
        return (a >= 64'h4000 && a < 64'h5000) || (a >= 64'h6000 && a < 64'h6800);
    endfunction

    function automatic logic [3:0] fault_code(input logic [63:0] a);
        return (a < 64'h5000) ? 4'd1 : 4'd5;
    endfunction

    function automatic logic [63:0] fault_val(input logic [63:0] a);
        return (a < 64'h5000) ? a : (a ^ 64'hFF00_0000);
    endfunction

    always_comb begin
        imem_instr    = mem_word(imem_addr);
        imem_exc_en   = fault_at(imem_addr);
        imem_exc_code = imem_exc_en ? fault_code(imem_addr) : 4'd0;
        imem_exc_val  = imem_exc_en ? fault_val(imem_addr) : 64'd0;
    end

    // ---------------- reference model: program stream from a start PC ----------------
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        exc_en;
        logic [3:0]  code;
        logic [63:0] val;
    } entry_t;

    entry_t sb_q[$];
    int     n_checks = 0;
    int     n_errors = 0;

    // Entries decode should see after fetch (re)starts at 'start': sequential words
    // until the first faulting address, which yields one fault entry and then nothing.
    task automatic push_stream(input logic [63:0] start);
        logic [63:0] a;
        entry_t      e;
        a = start;
        sb_q.delete();
        for (int i = 0; i < 256; i++) begin
            e.pc = a;
            if (a[1:0] != 2'b00) begin
                e.instr = NOP_INSTR; e.exc_en = 1'b1; e.code = 4'd0; e.val = a;
            end else if (fault_at(a)) begin
                e.instr = NOP_INSTR; e.exc_en = 1'b1; e.code = fault_code(a); e.val = fault_val(a);
            end else begin
                e.instr = mem_word(a); e.exc_en = 1'b0; e.code = 4'd0; e.val = 64'd0;
            end
            sb_q.push_back(e);
            if (e.exc_en) break;
            a = a + 64'd4;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    int     idle_cycles = 0;
    logic   stall_seen  = 1'b0;
    entry_t held;
    logic [63:0] held_addr;

    always @(negedge clk) begin
        entry_t exp_e;
        if (stall_seen) begin
            chk("stall_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_pc", out_pc, held.pc);
            chk("stall_instr", {32'd0, out_instr}, {32'd0, held.instr});
            chk("stall_exc", {59'd0, out_exc_en, out_exc_code}, {59'd0, held.exc_en, held.code});
            chk("stall_val", out_exc_val, held.val);
            chk("stall_addr", imem_addr, held_addr);
        end
        stall_seen = out_valid && !out_ready && !redirect_en && !rst;
        held       = '{pc: out_pc, instr: out_instr, exc_en: out_exc_en, code: out_exc_code, val: out_exc_val};
        held_addr  = imem_addr;

        if (rst || redirect_en) begin
            idle_cycles = 0;
        end else if (out_valid && out_ready) begin
            idle_cycles = 0;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL extra_entry: got pc %h expected no entry at %0t", out_pc, $time);
            end else begin
                exp_e = sb_q.pop_front();
                $display("accept pc=%h instr=%h exc=%0d code=%0d val=%h", out_pc, out_instr, out_exc_en, out_exc_code, out_exc_val);
                chk("entry_pc", out_pc, exp_e.pc);
                chk("entry_instr", {32'd0, out_instr}, {32'd0, exp_e.instr});
                chk("entry_exc_en", {63'd0, out_exc_en}, {63'd0, exp_e.exc_en});
                chk("entry_code", {60'd0, out_exc_code}, {60'd0, exp_e.code});
                chk("entry_val", out_exc_val, exp_e.val);
                if (exp_e.exc_en) chk("halt_on_fault", {63'd0, fetch_halted}, 64'd1);
            end
        end else if (out_ready && sb_q.size() > 0) begin
            // With decode ready, at most one bubble may follow a restart.
            idle_cycles++;
            n_checks++;
            if (idle_cycles == 2) begin
                n_errors++;
                $display("FAIL throughput: got %0d idle ready cycles expected at most 1 at %0t", idle_cycles, $time);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [63:0] t);
        redirect_en = 1'b1;
        redirect_pc = t;
        push_stream(t);
        $display("redirect to %h", t);
        step();
        redirect_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        push_stream(RESET_PC);
        step();
        rst = 1'b0;
    endtask

    initial begin
        int since_redirect;
        rst = 1'b1; redirect_en = 1'b0; redirect_pc = 64'd0; out_ready = 1'b0;
        push_stream(RESET_PC);
        step(); step();
        @(negedge clk);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_pc", out_pc, 64'd0);
        chk("rst_instr", {32'd0, out_instr}, {32'd0, NOP_INSTR});
        chk("rst_exc", {59'd0, out_exc_en, out_exc_code}, 64'd0);
        chk("rst_val", out_exc_val, 64'd0);
        chk("rst_halted", {63'd0, fetch_halted}, 64'd0);
        chk("rst_addr", imem_addr, RESET_PC);

        // Sequential fetch, then a three-cycle stall.
        step(); rst = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        out_ready = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
        repeat (2) step();

        // Redirect while stalled.
        out_ready = 1'b0;
        repeat (3) step();
        do_redirect(64'h40);
        @(negedge clk);
        chk("redir_flush", {63'd0, out_valid}, 64'd0);
        chk("redir_addr", imem_addr, 64'h40);
        out_ready = 1'b1;
        repeat (4) step();

        // imem access fault halts fetch until redirected.
        do_redirect(64'h4000);
        repeat (6) step();
        @(negedge clk);
        chk("fault_halted", {63'd0, fetch_halted}, 64'd1);
        chk("fault_no_entry", {63'd0, out_valid}, 64'd0);
        do_redirect(64'h0);
        @(negedge clk);
        chk("resume_halted", {63'd0, fetch_halted}, 64'd0);
        repeat (4) step();

        // Misaligned redirect held stalled, then reset out of HALT.
        out_ready = 1'b0;
        do_redirect(64'h102);
        repeat (3) step();
        @(negedge clk);
        chk("misal_valid", {63'd0, out_valid}, 64'd1);
        chk("misal_halted", {63'd0, fetch_halted}, 64'd1);
        chk("misal_pc", out_pc, 64'h102);
        chk("misal_code", {60'd0, out_exc_code}, 64'd0);
        chk("misal_val", out_exc_val, 64'h102);
        step();
        rst = 1'b1;
        push_stream(RESET_PC);
        step();
        @(negedge clk);
        chk("halt_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("halt_rst_halted", {63'd0, fetch_halted}, 64'd0);
        chk("halt_rst_addr", imem_addr, RESET_PC);
        step();
        rst = 1'b0; out_ready = 1'b1;
        repeat (4) step();

        // PC wrap-around at the top of the address space.
        do_redirect(64'hFFFF_FFFF_FFFF_FFF8);
        repeat (6) step();

        // Randomized phase.
        since_redirect = 0;
        for (int i = 0; i < 3000; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                since_redirect = 0;
            end else if ($urandom_range(0, 19) == 0 || since_redirect > 200) begin
                case ($urandom_range(0, 7))
                    0, 1, 2: do_redirect({49'd0, 13'($urandom_range(0, 8191)), 2'b00});
                    3:       do_redirect(64'h4000 + {52'd0, 10'($urandom_range(0, 1023)), 2'b00});
                    4:       do_redirect({49'd0, 13'($urandom_range(0, 8191)), 2'($urandom_range(1, 3))});
                    5:       do_redirect(64'hFFFF_FFFF_FFFF_FFE0 + {58'd0, 4'($urandom_range(0, 7)), 2'b00});
                    6:       do_redirect(64'h5FE0);
                    default: do_redirect(64'h3FF0);
                endcase
                since_redirect = 0;
            end else begin
                step();
                since_redirect++;
            end
        end
        out_ready = 1'b1;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage that sits directly upstream of the instruction memory. It owns the program counter and drives the imem address combinationally. It captures the returned instruction and any fetch exception into an IF/ID output register with a valid/ready handshake toward decode. It handles redirects (branch, jump, trap, mret) and halts fetch after a faulting fetch until it is redirected.

Parameters:
RESET_PC, 64'h0000_0000_0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, instruction word presented when no valid instruction is available (addi x0,x0,0)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
redirect_en  input  1  load redirect_pc into the PC and flush the output register
redirect_pc  input  64  redirect target
imem_addr  output  64  fetch address to imem (equals the PC register, combinational)
imem_instr  input  32  instruction word returned by imem, same cycle
imem_exc_en  input  1  imem access-fault flag
imem_exc_code  input  4  imem exception cause
imem_exc_val  input  64  imem faulting address
out_valid  output  1  IF/ID register holds a valid entry
out_ready  input  1  decode accepts the entry this cycle
out_pc  output  64  PC of the entry
out_instr  output  32  instruction of the entry
out_exc_en  output  1  entry carries a fetch exception
out_exc_code  output  4  exception cause
out_exc_val  output  64  mtval for the exception
fetch_halted  output  1  high while in HALT state

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - pc = RESET_PC; state = RUN
  - out_valid = 0; out_pc = 0; out_instr = NOP_INSTR
  - out_exc_en = 0; out_exc_code = 0; out_exc_val = 0
  - fetch_halted = 0
- Reset has priority over everything and aborts HALT or any stall.
- imem_addr = pc at all times. imem is combinational, so fetch-to-out_valid latency is 1 cycle.
- load = (state == RUN) && (!out_valid || out_ready) && !redirect_en.
- Exception detection on a fetch, in priority order:
  - pc[1:0] != 0: misaligned. exc_code = 0, exc_val = pc, imem outputs are ignored.
  - else if imem_exc_en: exc_code = imem_exc_code, exc_val = imem_exc_val.
- On load with no exception:
  - out_valid <= 1; out_pc <= pc; out_instr <= imem_instr; out_exc_* <= 0
  - pc <= pc + 4, modulo 2^64 (wraps silently)
- On load with an exception:
  - out_valid <= 1; out_pc <= pc; out_instr <= NOP_INSTR; out_exc_en <= 1; code/val as above
  - pc unchanged; state <= HALT
- Stall (out_valid && !out_ready && !redirect_en): all out_* and pc hold. imem_addr stays stable.
- When out_valid && out_ready and no load occurs (HALT state), out_valid <= 0.
- Redirect (redirect_en = 1), highest priority after rst:
  - pc <= redirect_pc; out_valid <= 0 (flushes the entry even if it is stalled or being accepted)
  - state <= RUN; no fetch is captured that cycle
  - The first fetch at the target occurs the next cycle.
- HALT state:
  - No loads occur; fetch_halted = 1.
  - The faulting entry stays presented until out_ready, then out_valid drops.
  - Exit only via redirect_en or rst.
- FSM: RUN → HALT on an exception load. HALT → RUN on redirect_en. Any state → RUN on rst.
- Simultaneous redirect_en and out_ready: the redirect wins and the entry is dropped. Decode must treat a redirect cycle's handshake as void.
- Throughput: 1 instruction per cycle while out_ready is held high.

Test Plan:
1. Release rst with out_ready = 1 and imem words A,B,C at 0x0/0x4/0x8 → out_valid rises 1 cycle later; out_pc = 0x0, 0x4, 0x8 on consecutive cycles; out_instr = A, B, C; out_exc_en = 0.
2. out_ready = 0 for 3 cycles while holding entry pc 0x4 → out_* and imem_addr = 0x8 are stable. When out_ready returns to 1, the next entry is out_pc = 0x8 with no skip or duplicate.
3. During a stall at out_pc 0x8, pulse redirect_en with redirect_pc = 0x40 → out_valid = 0 next cycle; imem_addr = 0x40; the following entry is out_pc = 0x40.
4. Redirect to 0x4000 (imem returns exc_en = 1, code 1, val 0x4000) → one entry with out_exc_en = 1, out_exc_code = 1, out_exc_val = 0x4000, out_instr = 0x00000013. fetch_halted = 1, and no further entries appear until a redirect to 0x0 resumes fetch.
5. Redirect to 0x102 → entry with out_exc_code = 0, out_exc_val = 0x102, out_pc = 0x102, and HALT is entered.
6. Assert rst while in HALT with out_valid = 1 → next cycle out_valid = 0, fetch_halted = 0, imem_addr = RESET_PC, and fetch resumes.
